// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared state encoding and helpers for the LUT config loader
// CHECK only exists when LUT_CONFIG_PARITY_EN is defined.
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
`ifdef LUT_CONFIG_PARITY_EN
    , CHECK = 2'd3
`endif
  } state_t;

  localparam int PARITY_MAX = 4096;

  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Even-parity bit: the value that makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/lut_config_shadow.sv
// rtl/lut_config_shadow.sv - shadow truth table assembled one beat at a time
module lut_config_shadow #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [CW-1:0]    idx,
  input  logic [CHUNK-1:0] data,
  output logic [WIDTH-1:0] shadow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (clear) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[int'(idx)*CHUNK +: CHUNK] <= data;
    end
  end

endmodule

// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - loads a LUT truth table in beats and commits it atomically
// Optional trailing parity beat check enabled by LUT_CONFIG_PARITY_EN.
module lut_config_loader
  import lut_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter int WIDTH  = 1 << INPUTS,
  parameter int CHUNK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] values,
  output logic             loaded,
  output logic             busy,
  output logic             error
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int CW    = beat_cnt_width(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (INPUTS < 1 || CHUNK < 1 || WIDTH < CHUNK) begin : g_bad_size
    $error("lut_config_loader: INPUTS, CHUNK and WIDTH must describe at least one beat");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("lut_config_loader: WIDTH must be a multiple of CHUNK");
  end
  if (WIDTH > PARITY_MAX) begin : g_bad_width
    $error("lut_config_loader: WIDTH exceeds parity helper range");
  end

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  shadow;
  logic              take;
  logic              beat_wr;
  logic              frame_clear;
  logic              commit_go;

  // Abort beats any coincident beat, so a beat only counts when abort is low.
  assign take        = in_valid & in_ready & ~abort;
  assign beat_wr     = (state == LOAD) & take;
  assign frame_clear = ((state == IDLE) & start) | ((state != IDLE) & abort);
  assign commit_go   = (state == COMMIT) & ~abort;

`ifdef LUT_CONFIG_PARITY_EN
  logic parity_ok;
  logic check_take;
  assign parity_ok  = (in_data[0] == even_parity(PARITY_MAX'(shadow)));
  assign check_take = (state == CHECK) & take;
`endif

  lut_config_shadow #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK),
    .CW    (CW)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clear  (frame_clear),
    .wr_en  (beat_wr),
    .idx    (cnt),
    .data   (in_data),
    .shadow (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (start) state_nxt = LOAD;
        LOAD: begin
          if (take && cnt == LAST) begin
`ifdef LUT_CONFIG_PARITY_EN
            state_nxt = CHECK;
`else
            state_nxt = COMMIT;
`endif
          end
        end
`ifdef LUT_CONFIG_PARITY_EN
        CHECK:  if (take) state_nxt = parity_ok ? COMMIT : IDLE;
`endif
        COMMIT: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == LOAD);
`ifdef LUT_CONFIG_PARITY_EN
    in_ready = in_ready | (state == CHECK);
`endif
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      values <= '0;
      loaded <= 1'b0;
    end else begin
      if (frame_clear)  cnt <= '0;
      else if (beat_wr) cnt <= cnt + 1'b1;
      if (commit_go) begin
        values <= shadow;
        loaded <= 1'b1;
      end
    end
  end

`ifdef LUT_CONFIG_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          error <= 1'b0;
    else if (state == IDLE && start)  error <= 1'b0;
    else if (check_take && !parity_ok) error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif

endmodule
